// File: rtl/sram8_word_bridge.sv
// Serializes PicoRV32 native 32-bit word accesses into four little-endian byte
// cycles on an 8-bit synchronous SRAM port with one-cycle registered read data.
//   state | meaning
//   IDLE  | waiting for a request
//   READ  | issuing byte reads k=0..3, capturing the previous byte
//   RCAP  | capturing the last read byte
//   WRITE | issuing byte writes k=0..3, gated by the latched strobes
//   DONE  | one-cycle mem_ready pulse
module sram8_word_bridge #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  output logic                  sram_ce,
  output logic                  sram_wre,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_wdata,
  input  logic [7:0]            sram_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    RCAP  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            k, k_nxt;
  logic [1:0]            k_prev;
  logic [ADDR_WIDTH-3:0] word_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic                  accept;

  // Address bits outside the SRAM word range are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH], mem_addr[1:0]};

  assign mem_ready = (state == DONE);
  assign mem_rdata = rdata_q;
  assign accept    = mem_valid && !mem_ready;
  assign k_prev    = k - 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k       <= 2'd0;
      word_q  <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == IDLE && accept) begin
        word_q  <= mem_addr[ADDR_WIDTH-1:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      // Read data lags the address by one cycle, so byte k-1 arrives during byte k.
      if (state == READ && k != 2'd0) begin
        rdata_q[{k_prev, 3'b000} +: 8] <= sram_rdata;
      end
      if (state == RCAP) begin
        rdata_q[31:24] <= sram_rdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    sram_ce    = 1'b0;
    sram_wre   = 1'b0;
    sram_addr  = '0;
    sram_wdata = 8'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          k_nxt     = 2'd0;
          state_nxt = (mem_wstrb != 4'd0) ? WRITE : READ;
        end
      end
      READ: begin
        sram_ce   = 1'b1;
        sram_addr = {word_q, k};
        k_nxt     = k + 2'd1;
        if (k == 2'd3) state_nxt = RCAP;
      end
      RCAP: begin
        state_nxt = DONE;
      end
      WRITE: begin
        sram_wre   = 1'b1;
        sram_ce    = wstrb_q[k];
        sram_addr  = {word_q, k};
        sram_wdata = wdata_q[{k, 3'b000} +: 8];
        k_nxt      = k + 2'd1;
        if (k == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
